// File: rtl/vc_status_table.sv
// Per-output-port VC status table: allocation FSM plus downstream credit counter
// for every (port, VC) pair. A VC is released only after its tail has left and all credits are back.
module vc_status_table #(
  parameter  int PORT_NUM  = 5,
  parameter  int VC_NUM    = 4,
  parameter  int BUF_DEPTH = 4,
  localparam int VW        = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [PORT_NUM-1:0]                    alloc_valid,
  input  logic [PORT_NUM-1:0][VW-1:0]            alloc_vc,
  input  logic [PORT_NUM-1:0]                    flit_sent,
  input  logic [PORT_NUM-1:0][VW-1:0]            flit_vc,
  input  logic [PORT_NUM-1:0]                    flit_tail,
  input  logic [PORT_NUM-1:0]                    credit_in,
  input  logic [PORT_NUM-1:0][VW-1:0]            credit_vc,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]        vc_busy,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]        vc_credit_ok,
  output logic [PORT_NUM-1:0][VC_NUM-1:0][CW-1:0] vc_credits,
  output logic [PORT_NUM-1:0]                    err,
  output logic [PORT_NUM-1:0][VC_NUM-1:0][1:0]   vc_state
);

  // Every event input is a single-cycle pulse qualified by its own strobe
  // (alloc_valid, flit_sent, credit_in); there is no backpressure, illegal events are dropped and flagged.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } vc_state_e;

  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  vc_state_e          state_q [PORT_NUM][VC_NUM];
  vc_state_e          state_d [PORT_NUM][VC_NUM];
  logic [CW-1:0]      cnt_q   [PORT_NUM][VC_NUM];
  logic [CW-1:0]      cnt_d   [PORT_NUM][VC_NUM];
  logic [PORT_NUM-1:0] err_q, err_d;

  logic [PORT_NUM-1:0]             alloc_ok, send_ok, credit_ok;
  logic [PORT_NUM-1:0][VC_NUM-1:0] send_hit, cred_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        for (int v = 0; v < VC_NUM; v++) begin
          state_q[p][v] <= S_IDLE;
          cnt_q[p][v]   <= FULL;
        end
      end
      err_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    alloc_ok  = '0;
    send_ok   = '0;
    credit_ok = '0;
    send_hit  = '0;
    cred_hit  = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      // Legality is decided by matching against real VC indices, so an
      // out-of-range index never matches and is flagged as illegal.
      for (int v = 0; v < VC_NUM; v++) begin
        if (alloc_vc[p] == VW'(v) && state_q[p][v] == S_IDLE)
          alloc_ok[p] = alloc_valid[p];
        if (flit_vc[p] == VW'(v) && state_q[p][v] == S_ACTIVE &&
            (cnt_q[p][v] != '0 || (credit_in[p] && credit_vc[p] == flit_vc[p])))
          send_ok[p] = flit_sent[p];
      end
      // A credit into a full counter is only legal when a same-VC send offsets it.
      for (int v = 0; v < VC_NUM; v++) begin
        if (credit_vc[p] == VW'(v) &&
            (cnt_q[p][v] != FULL || (send_ok[p] && flit_vc[p] == credit_vc[p])))
          credit_ok[p] = credit_in[p];
      end
      err_d[p] = err_q[p] | (alloc_valid[p] & ~alloc_ok[p]) |
                 (flit_sent[p] & ~send_ok[p]) | (credit_in[p] & ~credit_ok[p]);

      for (int v = 0; v < VC_NUM; v++) begin
        send_hit[p][v] = send_ok[p] && flit_vc[p] == VW'(v);
        cred_hit[p][v] = credit_ok[p] && credit_vc[p] == VW'(v);
        cnt_d[p][v]    = cnt_q[p][v] - CW'(send_hit[p][v]) + CW'(cred_hit[p][v]);
        case (state_q[p][v])
          S_IDLE: begin
            if (alloc_ok[p] && alloc_vc[p] == VW'(v)) state_d[p][v] = S_ACTIVE;
          end
          S_ACTIVE: begin
            if (send_hit[p][v] && flit_tail[p])
              state_d[p][v] = (cnt_d[p][v] == FULL) ? S_IDLE : S_DRAIN;
          end
          S_DRAIN: begin
            if (cnt_d[p][v] == FULL) state_d[p][v] = S_IDLE;
          end
          default: state_d[p][v] = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    vc_busy      = '0;
    vc_credit_ok = '0;
    vc_credits   = '0;
    vc_state     = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        vc_busy[p][v]      = state_q[p][v] != S_IDLE;
        vc_credit_ok[p][v] = state_q[p][v] == S_ACTIVE && cnt_q[p][v] != '0;
        vc_credits[p][v]   = cnt_q[p][v];
        vc_state[p][v]     = state_q[p][v];
      end
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_vc_status_table.sv
// Directed bench for vc_status_table with default parameters (5 ports, 4 VCs, depth 4).
module tb_vc_status_table;

  localparam int P = 5;
  localparam int V = 4;
  localparam int VW = 2;
  localparam int CW = 3;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_ACTIVE = 2'd1, ST_DRAIN = 2'd2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [P-1:0]              alloc_valid, flit_sent, flit_tail, credit_in;
  logic [P-1:0][VW-1:0]      alloc_vc, flit_vc, credit_vc;
  logic [P-1:0][V-1:0]       vc_busy, vc_credit_ok;
  logic [P-1:0][V-1:0][CW-1:0] vc_credits;
  logic [P-1:0]              err;
  logic [P-1:0][V-1:0][1:0]  vc_state;

  logic [P-1:0][V-1:0][CW-1:0] all_full;
  int n_tests = 0;
  int n_fail  = 0;

  vc_status_table dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_vc(alloc_vc),
    .flit_sent(flit_sent), .flit_vc(flit_vc), .flit_tail(flit_tail),
    .credit_in(credit_in), .credit_vc(credit_vc),
    .vc_busy(vc_busy), .vc_credit_ok(vc_credit_ok), .vc_credits(vc_credits),
    .err(err), .vc_state(vc_state)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    alloc_valid = '0; alloc_vc = '0;
    flit_sent = '0; flit_vc = '0; flit_tail = '0;
    credit_in = '0; credit_vc = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic alloc(input int p, input int v);
    alloc_valid[p] = 1'b1; alloc_vc[p] = VW'(v);
  endtask

  task automatic send(input int p, input int v, input logic tail);
    flit_sent[p] = 1'b1; flit_vc[p] = VW'(v); flit_tail[p] = tail;
  endtask

  task automatic cred(input int p, input int v);
    credit_in[p] = 1'b1; credit_vc[p] = VW'(v);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int p = 0; p < P; p++)
      for (int v = 0; v < V; v++) all_full[p][v] = 3'd4;
    clear_inputs();
    rst = 1'b1;
    #12;
    chk("rst_credits", 64'(vc_credits), 64'(all_full));
    chk("rst_busy", 64'(vc_busy), 64'd0);
    chk("rst_credit_ok", 64'(vc_credit_ok), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    tick();

    // Alloc p0 v2, then drain all credits with body flits.
    alloc(0, 2); tick();
    chk("a_busy", 64'(vc_busy[0][2]), 64'd1);
    chk("a_credit_ok", 64'(vc_credit_ok[0][2]), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      send(0, 2, 1'b0); tick();
      chk($sformatf("a_cnt_%0d", i), 64'(vc_credits[0][2]), 64'(4 - i));
      chk($sformatf("a_cok_%0d", i), 64'(vc_credit_ok[0][2]), (i < 4) ? 64'd1 : 64'd0);
    end
    chk("a_err_clean", 64'(err[0]), 64'd0);
    send(0, 2, 1'b0); tick();
    chk("a_overrun_err", 64'(err[0]), 64'd1);
    chk("a_overrun_cnt", 64'(vc_credits[0][2]), 64'd0);
    chk("a_overrun_state", 64'(vc_state[0][2]), 64'(ST_ACTIVE));

    // Head/body/tail on v1, drain via 3 credits, re-alloc.
    do_reset();
    alloc(0, 1); tick();
    send(0, 1, 1'b0); tick();
    send(0, 1, 1'b0); tick();
    send(0, 1, 1'b1); tick();
    chk("b_tail_cnt", 64'(vc_credits[0][1]), 64'd1);
    chk("b_tail_state", 64'(vc_state[0][1]), 64'(ST_DRAIN));
    chk("b_tail_cok", 64'(vc_credit_ok[0][1]), 64'd0);
    chk("b_tail_busy", 64'(vc_busy[0][1]), 64'd1);
    cred(0, 1); tick();
    chk("b_c1_cnt", 64'(vc_credits[0][1]), 64'd2);
    chk("b_c1_busy", 64'(vc_busy[0][1]), 64'd1);
    cred(0, 1); tick();
    chk("b_c2_busy", 64'(vc_busy[0][1]), 64'd1);
    cred(0, 1); tick();
    chk("b_c3_cnt", 64'(vc_credits[0][1]), 64'd4);
    chk("b_c3_busy", 64'(vc_busy[0][1]), 64'd0);
    chk("b_c3_state", 64'(vc_state[0][1]), 64'(ST_IDLE));
    alloc(0, 1); tick();
    chk("b_realloc_busy", 64'(vc_busy[0][1]), 64'd1);
    chk("b_realloc_cok", 64'(vc_credit_ok[0][1]), 64'd1);
    chk("b_realloc_err", 64'(err[0]), 64'd0);

    // cnt==0 with send and credit on the same VC together.
    alloc(1, 0); tick();
    for (int i = 0; i < 4; i++) begin
      send(1, 0, 1'b0); tick();
    end
    chk("c_empty_cnt", 64'(vc_credits[1][0]), 64'd0);
    send(1, 0, 1'b0); cred(1, 0); tick();
    chk("c_both_cnt", 64'(vc_credits[1][0]), 64'd0);
    chk("c_both_err", 64'(err[1]), 64'd0);
    chk("c_both_state", 64'(vc_state[1][0]), 64'(ST_ACTIVE));
    cred(1, 0); tick();
    chk("c_cred_cnt", 64'(vc_credits[1][0]), 64'd1);
    chk("c_cred_cok", 64'(vc_credit_ok[1][0]), 64'd1);

    // Port 3: alloc, send and credit on three different VCs in one cycle.
    alloc(3, 1); tick();
    alloc(3, 2); tick();
    send(3, 2, 1'b0); tick();
    alloc(3, 0); send(3, 1, 1'b0); cred(3, 2); tick();
    chk("d_busy", 64'(vc_busy[3]), 64'b0111);
    chk("d_cok", 64'(vc_credit_ok[3]), 64'b0111);
    chk("d_cnt0", 64'(vc_credits[3][0]), 64'd4);
    chk("d_cnt1", 64'(vc_credits[3][1]), 64'd3);
    chk("d_cnt2", 64'(vc_credits[3][2]), 64'd4);
    chk("d_cnt3", 64'(vc_credits[3][3]), 64'd4);
    chk("d_state3", 64'(vc_state[3][3]), 64'(ST_IDLE));
    chk("d_err", 64'(err[3]), 64'd0);

    // Illegal events, each from a clean reset.
    do_reset();
    alloc(2, 0); tick();
    alloc(2, 0); tick();
    chk("e_realloc_err", 64'(err[2]), 64'd1);
    chk("e_realloc_state", 64'(vc_state[2][0]), 64'(ST_ACTIVE));
    chk("e_realloc_cnt", 64'(vc_credits[2][0]), 64'd4);
    do_reset();
    alloc(2, 0); tick();
    cred(2, 0); tick();
    chk("e_overcred_err", 64'(err[2]), 64'd1);
    chk("e_overcred_cnt", 64'(vc_credits[2][0]), 64'd4);
    chk("e_overcred_cok", 64'(vc_credit_ok[2][0]), 64'd1);
    do_reset();
    send(2, 3, 1'b1); tick();
    chk("e_idle_send_err", 64'(err[2]), 64'd1);
    chk("e_idle_send_cnt", 64'(vc_credits[2][3]), 64'd4);
    chk("e_idle_send_busy", 64'(vc_busy[2]), 64'd0);
    chk("e_other_ports", 64'(err & 5'b11011), 64'd0);

    // Alloc and tail on the same VC together: alloc rejected, tail honoured.
    alloc(4, 0); tick();
    send(4, 0, 1'b0); tick();
    alloc(4, 0); send(4, 0, 1'b1); tick();
    chk("f_err", 64'(err[4]), 64'd1);
    chk("f_state", 64'(vc_state[4][0]), 64'(ST_DRAIN));
    chk("f_cnt", 64'(vc_credits[4][0]), 64'd2);

    // Reset asserted mid-DRAIN clears everything immediately.
    do_reset();
    alloc(0, 3); tick();
    send(0, 3, 1'b1); tick();
    cred(1, 0); tick();
    chk("g_pre_state", 64'(vc_state[0][3]), 64'(ST_DRAIN));
    chk("g_pre_cnt", 64'(vc_credits[0][3]), 64'd3);
    chk("g_pre_err", 64'(err[1]), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("g_rst_credits", 64'(vc_credits), 64'(all_full));
    chk("g_rst_busy", 64'(vc_busy), 64'd0);
    chk("g_rst_cok", 64'(vc_credit_ok), 64'd0);
    chk("g_rst_err", 64'(err), 64'd0);
    chk("g_rst_state", 64'(vc_state), 64'd0);
    #1;
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
